// File: rtl/axi4_mgr_pkg.sv
// Shared types and constants for the AXI4 manager command-port arbiter.
package axi4_mgr_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_DONE  = 2'd3
  } arb_state_t;

  localparam int MGR_REQ_WR_BIT = 0;
  localparam int MGR_REQ_RD_BIT = 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first active request at or above ptr, wrapping.
module rr_arbiter #(
  parameter int N = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic          valid
);

  localparam logic [PW:0] N_W = (PW+1)'(N);

  logic [PW:0]   sum;
  logic [PW-1:0] idx;

  always_comb begin
    grant = '0;
    valid = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      sum = {1'b0, ptr} + (PW+1)'(i);
      if (sum >= N_W) sum = sum - N_W;
      idx = sum[PW-1:0];
      if (!valid && req[idx]) begin
        grant[idx] = 1'b1;
        valid      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi4_mgr_arb.sv
// Shares one AXI4 manager command port between NUM_REQ requesters, one job at a time.
// state | meaning
// IDLE  | arbitrate, accept one job
// ISSUE | one-cycle mgr_req pulse (skipped for zero-count jobs)
// WAIT  | wait for matching manager done, watchdog running
// DONE  | done_o pulse to owner, advance rr pointer
module axi4_mgr_arb
  import axi4_mgr_pkg::*;
#(
  parameter int NUM_REQ          = 4,
  parameter int AXI_ADDR_WIDTH   = 32,
  parameter int DATA_COUNT_WIDTH = 8,
  parameter int TIMEOUT_CYCLES   = 4096
) (
  input  logic                                 clk_i,
  input  logic                                 rstn_i,
  input  logic [NUM_REQ-1:0]                   req_valid_i,
  output logic [NUM_REQ-1:0]                   req_ready_o,
  input  logic [NUM_REQ-1:0]                   req_we_i,
  input  logic [NUM_REQ*AXI_ADDR_WIDTH-1:0]    req_addr_i,
  input  logic [NUM_REQ*DATA_COUNT_WIDTH-1:0]  req_count_i,
  output logic [NUM_REQ-1:0]                   done_o,
  output logic [1:0]                           rsp_err_o,
  output logic [NUM_REQ-1:0]                   grant_o,
  output logic                                 timeout_o,
  output logic [1:0]                           mgr_req_o,
  output logic [AXI_ADDR_WIDTH-1:0]            mgr_wr_addr_o,
  output logic [AXI_ADDR_WIDTH-1:0]            mgr_rd_addr_o,
  output logic [DATA_COUNT_WIDTH-1:0]          mgr_wr_count_o,
  output logic [DATA_COUNT_WIDTH-1:0]          mgr_rd_count_o,
  input  logic                                 mgr_wr_done_i,
  input  logic                                 mgr_rd_done_i,
  input  logic [1:0]                           mgr_wr_err_i,
  input  logic [1:0]                           mgr_rd_err_i
);

  localparam int AW = AXI_ADDR_WIDTH;
  localparam int CW = DATA_COUNT_WIDTH;
  localparam int PW = $clog2(NUM_REQ);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] WDOG_LOAD = TW'(TIMEOUT_CYCLES - 1);

  arb_state_t state_q, state_d;

  logic [NUM_REQ-1:0] arb_grant;
  logic               arb_valid;
  logic [PW-1:0]      arb_idx;
  logic               sel_we;
  logic [AW-1:0]      sel_addr;
  logic [CW-1:0]      sel_cnt;
  logic               accept;
  logic               job_done;

  logic [PW-1:0]      rr_ptr_q;
  logic [PW-1:0]      owner_idx_q;
  logic [NUM_REQ-1:0] grant_q;
  logic               we_q;
  logic               zero_q;
  logic [AW-1:0]      wr_addr_q, rd_addr_q;
  logic [CW-1:0]      wr_cnt_q, rd_cnt_q;
  logic [1:0]         rsp_err_q;
  logic [TW-1:0]      wdog_q;
  logic               timeout_q;

  rr_arbiter #(.N(NUM_REQ)) u_rr_arbiter (
    .req   (req_valid_i),
    .ptr   (rr_ptr_q),
    .grant (arb_grant),
    .valid (arb_valid)
  );

  always_comb begin
    arb_idx  = '0;
    sel_we   = 1'b0;
    sel_addr = '0;
    sel_cnt  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_grant[i]) begin
        arb_idx  = PW'(i);
        sel_we   = req_we_i[i];
        sel_addr = req_addr_i[i*AW +: AW];
        sel_cnt  = req_count_i[i*CW +: CW];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state_q <= ARB_IDLE;
    else         state_q <= state_d;
  end

  // Zero-count jobs pass through ISSUE without a pulse, so done_o still lands two cycles after accept.
  always_comb begin
    state_d     = state_q;
    req_ready_o = '0;
    mgr_req_o   = '0;
    done_o      = '0;
    accept      = 1'b0;
    job_done    = we_q ? mgr_wr_done_i : mgr_rd_done_i;
    case (state_q)
      ARB_IDLE: begin
        if (arb_valid && rstn_i) begin
          req_ready_o = arb_grant;
          accept      = 1'b1;
          state_d     = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        if (zero_q) begin
          state_d = ARB_DONE;
        end else begin
          if (we_q) mgr_req_o[MGR_REQ_WR_BIT] = 1'b1;
          else      mgr_req_o[MGR_REQ_RD_BIT] = 1'b1;
          state_d = ARB_WAIT;
        end
      end
      ARB_WAIT: begin
        if (job_done) state_d = ARB_DONE;
      end
      ARB_DONE: begin
        done_o  = grant_q;
        state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rr_ptr_q    <= '0;
      owner_idx_q <= '0;
      grant_q     <= '0;
      we_q        <= 1'b0;
      zero_q      <= 1'b0;
      wr_addr_q   <= '0;
      rd_addr_q   <= '0;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      rsp_err_q   <= RESP_OKAY;
      wdog_q      <= '0;
      timeout_q   <= 1'b0;
    end else begin
      if (accept) begin
        grant_q     <= arb_grant;
        owner_idx_q <= arb_idx;
        we_q        <= sel_we;
        zero_q      <= (sel_cnt == '0);
        wr_addr_q   <= sel_we ? sel_addr : '0;
        rd_addr_q   <= sel_we ? '0 : sel_addr;
        wr_cnt_q    <= sel_we ? sel_cnt : '0;
        rd_cnt_q    <= sel_we ? '0 : sel_cnt;
      end
      if (state_q == ARB_ISSUE) begin
        wdog_q <= WDOG_LOAD;
        if (zero_q) rsp_err_q <= RESP_OKAY;
      end
      if (state_q == ARB_WAIT) begin
        if (wdog_q != '0) begin
          wdog_q <= wdog_q - TW'(1);
          if (wdog_q == TW'(1)) timeout_q <= 1'b1;
        end
        if (job_done) rsp_err_q <= we_q ? mgr_wr_err_i : mgr_rd_err_i;
      end
      if (state_q == ARB_DONE) begin
        grant_q   <= '0;
        wr_addr_q <= '0;
        rd_addr_q <= '0;
        wr_cnt_q  <= '0;
        rd_cnt_q  <= '0;
        rr_ptr_q  <= (owner_idx_q == PW'(NUM_REQ - 1)) ? '0 : owner_idx_q + PW'(1);
      end
    end
  end

  assign grant_o        = grant_q;
  assign rsp_err_o      = rsp_err_q;
  assign timeout_o      = timeout_q;
  assign mgr_wr_addr_o  = wr_addr_q;
  assign mgr_rd_addr_o  = rd_addr_q;
  assign mgr_wr_count_o = wr_cnt_q;
  assign mgr_rd_count_o = rd_cnt_q;

endmodule
